// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC and issues one
// instruction-memory request at a time. It captures the returned word and
// hands it to decode over a valid/ready handshake. A redirect from a taken
// jump/branch takes priority over everything except reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request; one bubble after reset or redirect
// FETCH | imem_req high at pc, waiting for imem_valid
// HOLD  | instruction captured, waiting for inst_ready
module fetch_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [3:0]        op,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       fetch_count,
    output logic              fetch_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        wait_cnt;
    logic [8:0]        wait_inc;

    assign wait_inc = {1'b0, wait_cnt} + 9'd1;

    // The PC only advances on an accepted handshake, so it is the address
    // of both the outstanding request and the held instruction.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_next   = pc + ADDR_W'(1);
    assign op        = inst_valid ? inst[DATA_W-1 -: 4] : 4'h0;

    // FSM, PC, captured instruction and accept counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inst        <= '0;
            inst_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Any response arriving now is dropped and any handshake is ignored.
            state      <= S_IDLE;
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_valid) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid  <= 1'b0;
                        pc          <= pc + ADDR_W'(1);
                        fetch_count <= fetch_count + 16'd1;
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (redirect) begin
            wait_cnt <= '0;
        end else if (state == S_FETCH) begin
            if (imem_valid) begin
                wait_cnt <= '0;
            end else begin
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_inc[7:0];
                end
                if (wait_inc >= 9'(TIMEOUT)) begin
                    fetch_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 4-bit-opcode processor. It holds the PC, issues one request at a time to instruction memory, and captures the returned instruction word. It presents the word, its 4-bit opcode and its PC to the decode/control stage through a valid/ready handshake. Taken jumps and branches redirect it, and it keeps an accepted-instruction counter and a fetch-timeout error flag.

## Interface
- DATA_W, 16, instruction word width; opcode is inst[DATA_W-1:DATA_W-4]
- ADDR_W, 16, PC / instruction address width (word addressed)
- RESET_PC, 0, PC loaded on reset
- TIMEOUT, 15, max cycles in FETCH without imem_valid before fetch_err sets (1..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  request to instruction memory
- imem_addr  out  ADDR_W  request address (= pc)
- imem_valid  in  1  response valid; meaningful only while imem_req=1
- imem_rdata  in  DATA_W  response data
- inst_valid  out  1  registered; inst/op/pc_out hold a fetched instruction
- inst_ready  in  1  decode stage accepts instruction
- inst  out  DATA_W  captured instruction word
- op  out  4  inst[DATA_W-1:DATA_W-4], feeds the control decoder
- pc_out  out  ADDR_W  address of inst
- pc_next  out  ADDR_W  pc_out+1 mod 2^ADDR_W, for the link register
- redirect  in  1  taken jump/branch (control PCWRITE qualified by execute)
- redirect_pc  in  ADDR_W  target address
- fetch_count  out  16  accepted instructions, wraps
- fetch_err  out  1  sticky timeout flag

## Operation
- States: IDLE, FETCH, HOLD. Reset sets:
  - state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, fetch_count=0, fetch_err=0, wait counter=0.
- IDLE:
  - imem_req=0.
  - Next state is FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_valid: inst<=imem_rdata, inst_valid<=1, wait counter<=0, go to HOLD.
  - Else: wait counter increments, saturating at 255. When it reaches TIMEOUT, fetch_err<=1 and stays 1 until reset. The request stays asserted.
- HOLD:
  - imem_req=0; inst, op and pc_out are stable.
  - If inst_ready: inst_valid<=0, pc<=pc+1 (wraps from 2^ADDR_W-1 to 0), fetch_count<=fetch_count+1, go to FETCH.
- Redirect has top priority, in any state:
  - pc<=redirect_pc, inst_valid<=0, wait counter<=0, go to IDLE.
  - Overrides a simultaneous imem_valid: the response is discarded and inst is not updated.
  - Overrides a simultaneous inst_ready: the instruction is not counted and pc is not incremented.
- Memory protocol:
  - Deasserting imem_req cancels any outstanding access.
  - The memory must not return data for a cancelled request. The IDLE cycle after a redirect guarantees imem_req is low for at least one cycle.
- op and pc_out are combinational from the inst and pc registers.
  - op reads 0 (add) whenever inst_valid=0, so consumers gate with inst_valid.
- Reset has priority over redirect and over every other input, including in the middle of a FETCH or HOLD.

## Timing
- Out of reset (reset low at edge 0):
  - Cycle 0: IDLE.
  - Cycle 1: FETCH with imem_req=1.
  - If imem_valid is high in cycle 1, inst_valid=1 in cycle 2.
- Throughput with zero-wait memory and inst_ready held high: one instruction per 2 cycles (FETCH, HOLD alternating).
- Each memory wait cycle adds one cycle.
- A redirect asserted in cycle n gives:
  - inst_valid=0 in cycle n+1;
  - IDLE in cycle n+1;
  - imem_req with imem_addr=redirect_pc in cycle n+2.
- Minimum redirect penalty is therefore 2 cycles before the new request.
- fetch_err sets on the edge where the wait counter reaches TIMEOUT. With TIMEOUT=15, that is the 15th consecutive FETCH cycle without imem_valid.
- fetch_count updates on the same edge as the accepting handshake.

## Test plan
- Reset, zero-wait memory returning 16'h1234 at pc 0, inst_ready=1 -> imem_addr=0 in cycle 1; inst_valid=1, op=4'h1, pc_out=0, pc_next=1 in cycle 2; imem_addr=1 in cycle 3; fetch_count=1.
- Backpressure: inst_ready=0 for 5 cycles while in HOLD -> inst, op and pc_out stable, imem_req=0, fetch_count unchanged. Raise ready -> exactly one increment, next address = pc+1.
- Redirect to 16'h0040 in the same cycle as imem_valid in FETCH -> response dropped, inst unchanged, IDLE, then imem_addr=16'h0040 two cycles after redirect.
- Redirect together with inst_ready in HOLD -> fetch_count not incremented, inst_valid=0 next cycle, fetch resumes at redirect_pc.
- PC wrap: RESET_PC=16'hFFFF, one accepted instruction -> next imem_addr=16'h0000, pc_next was 16'h0000.
- Memory never valid with TIMEOUT=15 -> fetch_err rises after the 15th FETCH cycle and stays 1 through a later redirect; cleared only by reset. Reset asserted mid-HOLD -> all outputs return to their reset values on the next edge.
